// File: rtl/pcileech_btn_ctl_pkg.sv
// Shared definitions for the PCILeech push-button conditioner: default
// timing constants for a 100 MHz clock, the reset-request FSM state type
// and a counter-width helper.
package pcileech_btn_ctl_pkg;

  // 10 ms debounce window at 100 MHz
  localparam int PCILEECH_BTN_DEBOUNCE_100MHZ = 1_000_000;
  // 2 s long-press threshold at 100 MHz
  localparam int PCILEECH_BTN_LONG_100MHZ     = 200_000_000;
  // Default stretch of the reset-request pulse
  localparam int PCILEECH_BTN_RST_REQ_CYCLES  = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } pcileech_btnrst_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcileech_btn_ctl_debounce.sv
// One button channel: 2-FF synchronizer, debounce counter that only
// accepts a new level after it has been stable for the full window, and a
// saturating hold counter that yields a single long-press pulse per press.
module pcileech_btn_ctl_debounce
  import pcileech_btn_ctl_pkg::*;
#(
  parameter int PARAM_DEBOUNCE_CYCLES = PCILEECH_BTN_DEBOUNCE_100MHZ,
  parameter int PARAM_LONG_CYCLES     = PCILEECH_BTN_LONG_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DCNT_W = cnt_w(PARAM_DEBOUNCE_CYCLES);
  localparam int LCNT_W = cnt_w(PARAM_LONG_CYCLES + 1);

  localparam logic [DCNT_W-1:0] DCNT_TERM = DCNT_W'(PARAM_DEBOUNCE_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(PARAM_LONG_CYCLES);
  localparam logic [LCNT_W-1:0] LCNT_PRE  = LCNT_W'(PARAM_LONG_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic sync0;
  (* ASYNC_REG = "TRUE" *) logic sync1;

  logic [DCNT_W-1:0] dcnt;
  logic [LCNT_W-1:0] lcnt;
  logic              toggle;
  logic              held;

  // Accept the synchronized value once it has differed from the current
  // level for the whole debounce window; "held" means the button is down
  // and stays down across this edge.
  always_comb begin
    toggle = (sync1 != btn_level) && (dcnt == DCNT_TERM);
    held   = btn_level && !toggle;
  end

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn_raw;
      sync1 <= sync0;
    end
  end

  // Debounce counter, accepted level and registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt        <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      if ((sync1 == btn_level) || toggle) begin
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DCNT_W'(1);
      end
      btn_level   <= btn_level ^ toggle;
      btn_press   <= toggle && !btn_level;
      btn_release <= toggle && btn_level;
    end
  end

  // Hold-time counter; saturation limits the long pulse to once per press,
  // and a release edge suppresses it so it never coincides with release.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt     <= '0;
      btn_long <= 1'b0;
    end else if (held) begin
      if (lcnt != LCNT_MAX) begin
        lcnt <= lcnt + LCNT_W'(1);
      end
      btn_long <= (lcnt == LCNT_PRE);
    end else begin
      lcnt     <= '0;
      btn_long <= 1'b0;
    end
  end

endmodule

// File: rtl/pcileech_btn_ctl.sv
// Board push-button conditioner: one debounce channel per button plus a
// small FSM that stretches a long press on the reset button into a
// fixed-length reset request. rst_req must only feed downstream resets,
// never this block's own rst, or the pulse would collapse to one cycle.
module pcileech_btn_ctl
  import pcileech_btn_ctl_pkg::*;
#(
  parameter int PARAM_NUM_BTN         = 2,
  parameter int PARAM_DEBOUNCE_CYCLES = PCILEECH_BTN_DEBOUNCE_100MHZ,
  parameter int PARAM_LONG_CYCLES     = PCILEECH_BTN_LONG_100MHZ,
  parameter int PARAM_RST_BTN         = 1,
  parameter int PARAM_RST_REQ_CYCLES  = PCILEECH_BTN_RST_REQ_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PARAM_NUM_BTN-1:0] btn_raw,
  output logic [PARAM_NUM_BTN-1:0] btn_level,
  output logic [PARAM_NUM_BTN-1:0] btn_press,
  output logic [PARAM_NUM_BTN-1:0] btn_release,
  output logic [PARAM_NUM_BTN-1:0] btn_long,
  output logic                     rst_req
);

  localparam int RCNT_W = cnt_w(PARAM_RST_REQ_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(PARAM_RST_REQ_CYCLES - 1);

  pcileech_btnrst_state_t state_q;
  pcileech_btnrst_state_t state_d;
  logic [RCNT_W-1:0]      rcnt_q;
  logic [RCNT_W-1:0]      rcnt_d;
  logic                   trig;

  for (genvar i = 0; i < PARAM_NUM_BTN; i++) begin : g_btn
    pcileech_btn_ctl_debounce #(
      .PARAM_DEBOUNCE_CYCLES (PARAM_DEBOUNCE_CYCLES),
      .PARAM_LONG_CYCLES     (PARAM_LONG_CYCLES)
    ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i])
    );
  end

  assign trig    = btn_long[PARAM_RST_BTN];
  assign rst_req = (state_q == REQ);

  // Reset-request state and stretch counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next-state logic: a long press arms or re-arms the request window.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = REQ;
          rcnt_d  = RCNT_LOAD;
        end
      end
      REQ: begin
        if (trig) begin
          rcnt_d = RCNT_LOAD;
        end else if (rcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q - RCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pcileech_btn_ctl.sv
// Bench for pcileech_btn_ctl: a table of timed input segments with
// hand-derived event times, then randomized button activity, all of it
// also compared cycle by cycle against a sliding-window reference model.
module tb_pcileech_btn_ctl;

  localparam int NB = 2;
  localparam int D  = 8;
  localparam int L  = 32;
  localparam int R  = 4;
  localparam int RB = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;
  logic          rst_req;

  always #5 clk = ~clk;

  pcileech_btn_ctl #(
    .PARAM_NUM_BTN         (NB),
    .PARAM_DEBOUNCE_CYCLES (D),
    .PARAM_LONG_CYCLES     (L),
    .PARAM_RST_BTN         (RB),
    .PARAM_RST_REQ_CYCLES  (R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .rst_req     (rst_req)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_level, m_press, m_release, m_long, prev_long;
  logic          m_req;
  int            edge_n = 0;
  int            press_edge[NB];
  int            req_until;

  // Per-segment event record (step index of first occurrence, -1 = none)
  int f_press[NB], f_rel[NB], f_long[NB];
  int req_first, req_cnt;

  // A level change is accepted when the last D synchronized samples all
  // disagree with the current level; long fires L edges after the press
  // unless released first; rst_req covers R edges after a reset-button long.
  task automatic model_edge(input logic r, input logic [NB-1:0] rw);
    edge_n++;
    if (r) begin
      hist.delete();
      for (int j = 0; j < D + 1; j++) hist.push_back('0);
      m_level = '0; m_press = '0; m_release = '0; m_long = '0;
      prev_long = '0; m_req = 1'b0; req_until = -1;
      for (int b = 0; b < NB; b++) press_edge[b] = -1;
    end else begin
      if (prev_long[RB]) req_until = edge_n - 1 + R;
      for (int b = 0; b < NB; b++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = 2; j <= D + 1; j++)
          if (hist[hist.size() - j][b] == m_level[b]) all_diff = 1'b0;
        m_press[b] = 1'b0; m_release[b] = 1'b0; m_long[b] = 1'b0;
        if (all_diff) begin
          if (!m_level[b]) begin
            m_press[b] = 1'b1; m_level[b] = 1'b1; press_edge[b] = edge_n;
          end else begin
            m_release[b] = 1'b1; m_level[b] = 1'b0; press_edge[b] = -1;
          end
        end
        if (press_edge[b] >= 0 && edge_n == press_edge[b] + L) m_long[b] = 1'b1;
      end
      hist.push_back(rw);
      if (hist.size() > D + 2) void'(hist.pop_front());
      m_req = (edge_n <= req_until);
      prev_long = m_long;
    end
  endtask

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, edge_n, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int row, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL row%0d %s: got %0d expected %0d", row, nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [NB-1:0] rw, input int k);
    @(negedge clk);
    rst = r;
    btn_raw = rw;
    @(posedge clk);
    model_edge(r, rw);
    #1;
    chk("btn_level",   btn_level,   m_level);
    chk("btn_press",   btn_press,   m_press);
    chk("btn_release", btn_release, m_release);
    chk("btn_long",    btn_long,    m_long);
    chk("rst_req",     {1'b0, rst_req}, {1'b0, m_req});
    for (int b = 0; b < NB; b++) begin
      if (btn_press[b]   && f_press[b] < 0) f_press[b] = k;
      if (btn_release[b] && f_rel[b]   < 0) f_rel[b]   = k;
      if (btn_long[b]    && f_long[b]  < 0) f_long[b]  = k;
    end
    if (rst_req) begin
      if (req_first < 0) req_first = k;
      req_cnt++;
    end
  endtask

  typedef struct {
    logic          rst;
    logic [NB-1:0] raw;
    int            n;
    int            press0, press1, rel0, rel1, long0, long1;
    int            req_first, req_cnt;
    logic [NB-1:0] level_end;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    rst = 1'b1;
    btn_raw = '0;

    //            rst   raw  n   p0  p1  r0  r1  l0  l1  rqf rqc  lvl
    vecs[0]  = '{1'b1, 2'b00,  3, -1, -1, -1, -1, -1, -1, -1, 0, 2'b00}; // reset state
    vecs[1]  = '{1'b0, 2'b01, 45,  9, -1, -1, -1, 41, -1, -1, 0, 2'b01}; // clean press
    vecs[2]  = '{1'b0, 2'b00, 12, -1, -1,  9, -1, -1, -1, -1, 0, 2'b00}; // saturated release
    vecs[3]  = '{1'b0, 2'b01,  5, -1, -1, -1, -1, -1, -1, -1, 0, 2'b00}; // bounce
    vecs[4]  = '{1'b0, 2'b00,  2, -1, -1, -1, -1, -1, -1, -1, 0, 2'b00};
    vecs[5]  = '{1'b0, 2'b01,  7, -1, -1, -1, -1, -1, -1, -1, 0, 2'b00};
    vecs[6]  = '{1'b0, 2'b00, 12, -1, -1, -1, -1, -1, -1, -1, 0, 2'b00};
    vecs[7]  = '{1'b0, 2'b01,  8, -1, -1, -1, -1, -1, -1, -1, 0, 2'b00}; // exact window
    vecs[8]  = '{1'b0, 2'b00, 12,  1, -1,  9, -1, -1, -1, -1, 0, 2'b00};
    vecs[9]  = '{1'b0, 2'b10, 60, -1,  9, -1, -1, -1, 41, 42, 4, 2'b10}; // long on reset btn
    vecs[10] = '{1'b0, 2'b00, 12, -1, -1, -1,  9, -1, -1, -1, 0, 2'b00};
    vecs[11] = '{1'b0, 2'b11, 12,  9,  9, -1, -1, -1, -1, -1, 0, 2'b11}; // simultaneous
    vecs[12] = '{1'b0, 2'b00, 12, -1, -1,  9,  9, -1, -1, -1, 0, 2'b00};
    vecs[13] = '{1'b0, 2'b01, 32,  9, -1, -1, -1, -1, -1, -1, 0, 2'b01}; // release at long edge
    vecs[14] = '{1'b0, 2'b00, 12, -1, -1,  9, -1, -1, -1, -1, 0, 2'b00};
    vecs[15] = '{1'b0, 2'b10, 43, -1,  9, -1, -1, -1, 41, 42, 1, 2'b10}; // into REQ
    vecs[16] = '{1'b1, 2'b10,  2, -1, -1, -1, -1, -1, -1, -1, 0, 2'b00}; // reset mid-REQ
    vecs[17] = '{1'b0, 2'b10, 45, -1,  9, -1, -1, -1, 41, 42, 3, 2'b10}; // held through reset
    vecs[18] = '{1'b1, 2'b00,  2, -1, -1, -1, -1, -1, -1, -1, 0, 2'b00};

    for (int v = 0; v < NV; v++) begin
      for (int b = 0; b < NB; b++) begin
        f_press[b] = -1; f_rel[b] = -1; f_long[b] = -1;
      end
      req_first = -1;
      req_cnt = 0;
      for (int k = 0; k < vecs[v].n; k++) step(vecs[v].rst, vecs[v].raw, k);
      chk_int("press0",    v, f_press[0], vecs[v].press0);
      chk_int("press1",    v, f_press[1], vecs[v].press1);
      chk_int("release0",  v, f_rel[0],   vecs[v].rel0);
      chk_int("release1",  v, f_rel[1],   vecs[v].rel1);
      chk_int("long0",     v, f_long[0],  vecs[v].long0);
      chk_int("long1",     v, f_long[1],  vecs[v].long1);
      chk_int("req_first", v, req_first,  vecs[v].req_first);
      chk_int("req_cnt",   v, req_cnt,    vecs[v].req_cnt);
      chk_int("level_end", v, int'(btn_level), int'(vecs[v].level_end));
    end

    // Randomized activity: short bounces, near-window holds, long holds
    // and occasional resets, checked every edge against the model.
    begin
      int total;
      total = 0;
      while (total < 4000) begin
        logic [NB-1:0] rw;
        logic          r;
        int            hold;
        rw   = NB'($urandom_range(0, 3));
        r    = ($urandom_range(0, 40) == 0);
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 60))
                                           : int'($urandom_range(1, 12));
        for (int k = 0; k < hold; k++) step((k == 0) ? r : 1'b0, rw, k);
        total += hold;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcileech_btn_ctl.md
# pcileech_btn_ctl

Board push-button conditioner for the PCILeech FPGA tops: synchronizes and debounces the raw GPIO buttons, then emits clean levels, one-cycle press/release pulses and a long-press event. A long press on a designated button produces a stretched reset-request pulse. The top ORs this pulse into its power-on reset, replacing raw button use in reset and LED logic. Runs in the 100 MHz `clk` domain.

## Interface
Parameters:
- `PARAM_NUM_BTN`, 2: number of buttons (1..8).
- `PARAM_DEBOUNCE_CYCLES`, 1_000_000: stable cycles required to accept a change (10 ms at 100 MHz); must be ≥2.
- `PARAM_LONG_CYCLES`, 200_000_000: debounced-high cycles that define a long press (2 s); must be > `PARAM_DEBOUNCE_CYCLES`.
- `PARAM_RST_BTN`, 1: index of the button whose long press raises `rst_req`.
- `PARAM_RST_REQ_CYCLES`, 64: length of the `rst_req` pulse in cycles.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `btn_raw` in `PARAM_NUM_BTN`: asynchronous raw buttons, active-high.
- `btn_level` out `PARAM_NUM_BTN`: debounced button level.
- `btn_press` out `PARAM_NUM_BTN`: one-cycle pulse on a debounced 0→1 change.
- `btn_release` out `PARAM_NUM_BTN`: one-cycle pulse on a debounced 1→0 change.
- `btn_long` out `PARAM_NUM_BTN`: one-cycle pulse, at most once per press.
- `rst_req` out 1: stretched reset request.

## Operation
- Per button, `btn_raw` passes through a 2-FF synchronizer (`sync0`, `sync1`). The synchronizer flops carry ASYNC_REG.
- Debounce counter `dcnt`, width `$clog2(PARAM_DEBOUNCE_CYCLES)`:
  - Cleared whenever `sync1 == btn_level`.
  - Otherwise incremented.
  - When `sync1 != btn_level` and `dcnt == PARAM_DEBOUNCE_CYCLES-1`: `btn_level` toggles and `dcnt` clears.
  - Any bounce back to the old value before terminal count clears `dcnt`, so no output change occurs.
- `btn_press` / `btn_release` are registered. They are high in exactly the first cycle in which the new `btn_level` is visible.
- Long-press counter `lcnt`, width `$clog2(PARAM_LONG_CYCLES+1)`:
  - Cleared while `btn_level == 0`.
  - Increments while `btn_level == 1`, saturating at `PARAM_LONG_CYCLES`.
  - `btn_long` pulses in the cycle in which `lcnt` becomes `PARAM_LONG_CYCLES`.
  - Saturation guarantees a single pulse per press. Only a release and a new press re-arm it.
- Reset-request FSM (states `IDLE`, `REQ`):
  - `IDLE` → `REQ` on `btn_long[PARAM_RST_BTN]`. `rcnt` is loaded with `PARAM_RST_REQ_CYCLES-1`.
  - In `REQ`, `rst_req` is 1 and `rcnt` decrements. At `rcnt == 0` and with no retrigger, the FSM returns to `IDLE`.
  - A retrigger in `REQ` reloads `rcnt`. This only occurs after a release and a second long press.
- Buttons are independent. Simultaneous presses produce simultaneous pulses on all affected bits.
- `rst_req` must NOT be routed back into this block's `rst`. Doing so would truncate the pulse to one cycle. The top ORs `rst_req` only into the downstream reset.

## Timing
Reset values:
- All outputs 0.
- `sync0`, `sync1`, `dcnt`, `lcnt`, `rcnt` are 0.
- FSM is in `IDLE`.

Reset behaviour:
- Reset asserted mid-press or mid-`REQ` aborts immediately. No pulse is emitted during or because of reset.
- A button held through reset release is treated as a new press: `btn_press` fires after full debounce.

Latencies (cycle 0 = first `clk` edge sampling the new `btn_raw` into `sync0`, input stable thereafter):
- `sync1` is updated at edge 1.
- `btn_level` / `btn_press` / `btn_release` are updated at edge 1+`PARAM_DEBOUNCE_CYCLES`.
- `btn_long` pulses `PARAM_LONG_CYCLES` cycles after `btn_press`.
- `rst_req` rises one cycle after `btn_long[PARAM_RST_BTN]`. It stays high for exactly `PARAM_RST_REQ_CYCLES` cycles.

Boundary conditions:
- A glitch shorter than `PARAM_DEBOUNCE_CYCLES` produces no output activity.
- A glitch of exactly `PARAM_DEBOUNCE_CYCLES` stable cycles is accepted.
- `btn_long` and `btn_release` never coincide. A release while `lcnt` is saturated only produces `btn_release`.

## Structure
- Shared package (`pcileech_header.svh`):
  - Default constants `PCILEECH_BTN_DEBOUNCE_100MHZ` and `PCILEECH_BTN_LONG_100MHZ`.
  - Enum `pcileech_btnrst_state_t {IDLE, REQ}`.
- Sub-module `pcileech_btn_debounce`, one instance per button via generate. It contains the synchronizer, `dcnt`, `lcnt` and the pulse outputs.
- The top-level block holds the generate loop and the reset-request FSM.
- Expected size is about 150–200 lines.

## Test plan
All scenarios use `PARAM_DEBOUNCE_CYCLES`=8, `PARAM_LONG_CYCLES`=32, `PARAM_RST_REQ_CYCLES`=4, `PARAM_NUM_BTN`=2, `PARAM_RST_BTN`=1.

- **Clean press:** raise `btn_raw[0]` and hold → `btn_level[0]` rises and `btn_press[0]` pulses 1 cycle at edge 9; `btn_long[0]` pulses at edge 41; `rst_req` stays 0.
- **Bounce rejection:** toggle `btn_raw[0]` high 5 cycles, low 2, high 7, then low → no output ever changes.
- **Long press on reset button:** hold `btn_raw[1]` → `btn_long[1]` pulses at edge 41; `rst_req` high for edges 42–45, then 0; continued holding gives no second pulse. Release → `btn_release[1]` pulses 9 cycles after release.
- **Simultaneous buttons:** raise both bits in the same cycle → `btn_press` == 2'b11 for exactly one cycle.
- **Reset mid-operation:** assert `rst` during `REQ` → `rst_req` drops the next cycle. Release `rst` while `btn_raw[1]` is still high → `btn_press[1]` fires 9 cycles later, and `btn_long[1]` fires 32 cycles after that.
